// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default parameters for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_e;

  localparam int unsigned MULDIV_LAT_DEF = 32;
  localparam int unsigned REG_W_DEF      = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stage-register controls back to it.
interface pipeline_hazard_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             ex_muldiv;
  logic             ex_mispredict;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_stall;
  logic             id_stall;
  logic             id_flush;
  logic             ex_stall;
  logic             ex_flush;
  logic             mem_stall;
  logic             mem_flush;
  logic             wb_flush;
  logic             muldiv_busy;
  logic             muldiv_last;
  logic [31:0]      stall_cycles;

  // Pipeline side: reports hazards, receives controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_muldiv, ex_mispredict, imem_ready, dmem_req, dmem_ready,
    input  pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
           mem_flush, wb_flush, muldiv_busy, muldiv_last, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_muldiv, ex_mispredict, imem_ready, dmem_req, dmem_ready,
    output pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
           mem_flush, wb_flush, muldiv_busy, muldiv_last, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: EX load whose destination feeds ID.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load to it never creates a dependency.
    load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: priority mux, mul/div FSM and
// stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int unsigned REG_W      = REG_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned          CNT_W    = $clog2(MULDIV_LAT);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic dmem_wait;

  logic pc_stall, id_stall, id_flush, ex_stall, ex_flush;
  logic mem_stall, mem_flush, wb_flush, muldiv_busy, muldiv_last;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_rs1     (hz.id_rs1),
    .id_rs2     (hz.id_rs2),
    .id_use_rs1 (hz.id_use_rs1),
    .id_use_rs2 (hz.id_use_rs2),
    .ex_rd      (hz.ex_rd),
    .ex_is_load (hz.ex_is_load),
    .load_use   (load_use)
  );

  always_comb begin
    dmem_wait   = hz.dmem_req && !hz.dmem_ready;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_stall    = 1'b0;
    ex_flush    = 1'b0;
    mem_stall   = 1'b0;
    mem_flush   = 1'b0;
    wb_flush    = 1'b0;
    muldiv_last = 1'b0;
    muldiv_busy = (state_q == MULDIV);

    if (dmem_wait) begin
      // Whole pipe frozen; FSM and counter hold so mul/div time extends.
      pc_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      wb_flush  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.ex_muldiv) begin
            pc_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_flush = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = MULDIV;
          end else if (hz.ex_mispredict) begin
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall = 1'b1;
            id_stall = 1'b1;
            ex_flush = 1'b1;
          end else if (!hz.imem_ready) begin
            pc_stall = 1'b1;
            id_flush = 1'b1;
          end
        end
        MULDIV: begin
          if (cnt_q != '0) begin
            pc_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_flush = 1'b1;
            cnt_d     = cnt_q - 1'b1;
          end else begin
            muldiv_last = 1'b1;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (rst) begin
      pc_stall    = 1'b0;
      id_stall    = 1'b0;
      id_flush    = 1'b0;
      ex_stall    = 1'b0;
      ex_flush    = 1'b0;
      mem_stall   = 1'b0;
      mem_flush   = 1'b0;
      wb_flush    = 1'b0;
      muldiv_busy = 1'b0;
      muldiv_last = 1'b0;
    end

    stall_cycles_d = stall_cycles_q + {31'd0, pc_stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.id_stall     = id_stall;
  assign hz.id_flush     = id_flush;
  assign hz.ex_stall     = ex_stall;
  assign hz.ex_flush     = ex_flush;
  assign hz.mem_stall    = mem_stall;
  assign hz.mem_flush    = mem_flush;
  assign hz.wb_flush     = wb_flush;
  assign hz.muldiv_busy  = muldiv_busy;
  assign hz.muldiv_last  = muldiv_last;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage core. It drives the stall and flush inputs of the ID, EX, MEM and WB stage registers and the PC-hold of the fetch stage. Its inputs are load-use hazards, branch mispredicts, multi-cycle mul/div occupancy of EX, and instruction/data memory wait states. Stage registers give stall priority over flush, so this block never asserts both stall and flush for the same register in the same cycle.

## Interface
- MULDIV_LAT, 32, total cycles a mul/div occupies EX (≥2)
- REG_W, 5, register-index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_W  source indices of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
- ex_rd  in  REG_W  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_muldiv  in  1  EX instruction is mul/div
- ex_mispredict  in  1  branch resolved in EX disagrees with prediction
- imem_ready  in  1  fetch data valid this cycle
- dmem_req, dmem_ready  in  1  MEM access pending / completing
- pc_stall  out  1  hold PC
- id_stall, id_flush, ex_stall, ex_flush, mem_stall, mem_flush, wb_flush  out  1  stage-register controls
- muldiv_busy  out  1  FSM in MULDIV
- muldiv_last  out  1  final EX cycle of mul/div; EX captures result
- stall_cycles  out  32  count of cycles with pc_stall=1, wraps

## Operation
- FSM states: RUN, MULDIV. Counter cnt is ceil(log2(MULDIV_LAT)) bits wide.
- dmem_wait = dmem_req & ~dmem_ready.
- load_use = ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority, first match wins; all unlisted outputs are 0:
  1. dmem_wait, any state: pc/id/ex/mem stall, wb_flush. FSM state and cnt hold.
  2. RUN & ex_muldiv: pc/id/ex stall, mem_flush. cnt←MULDIV_LAT−2; go to MULDIV.
  3. MULDIV & cnt≠0: pc/id/ex stall, mem_flush; cnt−−.
  4. MULDIV & cnt==0: muldiv_last=1, no stalls; go to RUN.
  5. RUN & ex_mispredict: id_flush, ex_flush. PC loads the redirect target; pc_stall=0.
  6. RUN & load_use: pc_stall, id_stall, ex_flush (one bubble).
  7. RUN & ~imem_ready: pc_stall, id_flush.
- In MULDIV, ex_mispredict, load_use and imem_ready are ignored; ID is held, not flushed.
- stall_cycles increments on every cycle with pc_stall=1.

## Timing
- All control outputs are combinational from state, cnt and inputs. Only state, cnt and stall_cycles are registered.
- Reset (rst=1 at a clock edge): state=RUN, cnt=0, stall_cycles=0.
  - While rst=1, every stall, flush, muldiv_busy and muldiv_last output is forced to 0.
  - rst mid-MULDIV returns to RUN on the next edge.
- Mul/div occupies EX for exactly MULDIV_LAT unfrozen cycles. Cycles frozen by dmem_wait are added on top.
- Back-to-back mul/div: the second one enters EX the cycle after muldiv_last and retriggers from RUN.
- Load-use costs exactly 1 bubble. The next cycle EX holds the bubble and load_use deasserts.
- Mispredict costs 2 bubbles (ID, EX). Mispredict together with load_use resolves as mispredict only.
- ex_rd==0 never triggers load_use.

## Structure
- Package pipeline_ctrl_pkg:
  - state enum {RUN, MULDIV}
  - MULDIV_LAT default
  - REG_W
- Sub-module hazard_detect: purely combinational load_use comparator, instantiated once.
- FSM, cnt, priority mux and stall_cycles counter live in the top.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_stall=id_stall=ex_flush=1, next cycle all 0. Repeat with ex_rd=0 → no stall.
- Mul/div, MULDIV_LAT=4: ex_muldiv=1 in RUN → stalls for cycles 1–3, muldiv_last=1 at cycle 4, muldiv_busy=1 at cycles 2–4, back to RUN at cycle 5.
- dmem_wait for 2 cycles in the middle of MULDIV → pc/id/ex/mem stall, wb_flush, cnt frozen; muldiv_last arrives 2 cycles later (cycle 6).
- ex_mispredict=1 with load_use=1 and imem_ready=0 → id_flush=ex_flush=1, pc_stall=0.
- imem_ready=0 for 3 cycles in RUN → pc_stall=id_flush=1 for each; stall_cycles advances by 3.
- rst=1 in MULDIV with cnt=2 → all outputs 0 during reset; state RUN and stall_cycles=0 after the edge.
- Every scenario: assert X_stall & X_flush is never 1 for any stage register.
